// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg: station indices, scheduler state encodings and LFSR taps
package nexys_starship_pkg;
  localparam int ST_L = 0;
  localparam int ST_R = 1;
  localparam int ST_U = 2;
  localparam int ST_D = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ARMED  = 4'b0010,
    S_SELECT = 4'b0100,
    S_ISSUE  = 4'b1000
  } state_e;
endpackage

// File: rtl/nexys_starship_lfsr16.sv
// nexys_starship_lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1)
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge Clk)
    if (Reset) lfsr_q <= SEED;
    else lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/nexys_starship_break_sched.sv
// nexys_starship_break_sched: paced, capped break scheduler for the four repair stations
module nexys_starship_break_sched
  import nexys_starship_pkg::*;
#(
  parameter int          NUM_ST           = 4,
  parameter int          COOLDOWN_TICKS   = 8,
  parameter int          MIN_COOLDOWN     = 2,
  parameter int          MAX_BROKEN       = 2,
  parameter int          BREAKS_PER_LEVEL = 16,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              timer_tick,
  input  logic              play_flag,
  input  logic              gameover_ctrl,
  input  logic [NUM_ST-1:0] broken,
  input  logic [NUM_ST-1:0] shield,
  output logic [NUM_ST-1:0] break_pulse,
  output logic [3:0]        break_combo,
  output logic [2:0]        broken_cnt,
  output logic [2:0]        level,
  output logic              q_BS_Idle,
  output logic              q_BS_Armed,
  output logic              q_BS_Select,
  output logic              q_BS_Issue
);
  state_e      state_q;
  logic [4:0]  cool_q;
  logic [7:0]  issue_cnt_q;
  logic [2:0]  level_q;
  logic [15:0] lfsr;
  logic [NUM_ST-1:0] elig;
  logic [1:0]  sel;
  logic [3:0]  combo_d;
  logic [2:0]  level_d;
  logic [4:0]  cool_diff, cool_d;
  logic        issue_wrap, unused_lfsr;

  function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] s);
    logic [1:0] r;
    r = s;
    for (int k = 3; k >= 0; k--) if (e[s + 2'(k)]) r = s + 2'(k);
    return r;
  endfunction

  nexys_starship_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .Reset(Reset), .lfsr_o(lfsr));

  assign unused_lfsr = ^{lfsr[15:8], lfsr[3:2]};
  assign elig        = ~broken & ~shield;
  assign sel         = pick(elig, lfsr[1:0]);
  assign combo_d     = lfsr[7:4] == 4'h0 ? 4'h1 : lfsr[7:4];
  assign broken_cnt  = 3'($countones(broken));
  assign issue_wrap  = issue_cnt_q == 8'(BREAKS_PER_LEVEL - 1);
  assign level_d     = issue_wrap && level_q != 3'd7 ? level_q + 3'd1 : level_q;
  // sign bit of the 5-bit difference flags an over-ramped level
  assign cool_diff   = 5'(COOLDOWN_TICKS) - {2'b00, level_d};
  assign cool_d      = cool_diff[4] || cool_diff < 5'(MIN_COOLDOWN) ? 5'(MIN_COOLDOWN) : cool_diff;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      break_pulse <= '0;
      break_combo <= '0;
      level_q     <= '0;
      cool_q      <= '0;
      issue_cnt_q <= '0;
    end else begin
      break_pulse <= '0;
      if (gameover_ctrl) state_q <= S_IDLE;
      else case (state_q)
        S_IDLE: begin
          cool_q <= 5'(COOLDOWN_TICKS);
          if (play_flag) begin
            state_q     <= S_ARMED;
            level_q     <= '0;
            issue_cnt_q <= '0;
          end
        end
        S_ARMED:
          if (!play_flag) state_q <= S_IDLE;
          else if (cool_q == '0) begin
            if (broken_cnt < 3'(MAX_BROKEN)) state_q <= S_SELECT;
          end else if (timer_tick) cool_q <= cool_q - 5'd1;
        S_SELECT:
          if (!play_flag) state_q <= S_IDLE;
          else if (elig == '0) begin
            state_q <= S_ARMED;
            cool_q  <= 5'd1;
          end else begin
            state_q     <= S_ISSUE;
            break_pulse <= NUM_ST'(1) << sel;
            break_combo <= combo_d;
          end
        S_ISSUE: begin
          state_q     <= S_ARMED;
          issue_cnt_q <= issue_wrap ? '0 : issue_cnt_q + 8'd1;
          level_q     <= level_d;
          cool_q      <= cool_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign level       = level_q;
  assign q_BS_Idle   = state_q == S_IDLE;
  assign q_BS_Armed  = state_q == S_ARMED;
  assign q_BS_Select = state_q == S_SELECT;
  assign q_BS_Issue  = state_q == S_ISSUE;
endmodule

// File: tb/tb_nexys_starship_break_sched.sv
// tb_nexys_starship_break_sched: directed scenarios with a pulse scoreboard and LFSR reference
module tb_nexys_starship_break_sched;
  import nexys_starship_pkg::*;
  logic clk = 0, reset = 1, timer_tick = 0, play_flag = 0, gameover_ctrl = 0;
  logic [3:0] broken = 0, shield = 0, break_pulse, break_combo;
  logic [2:0] broken_cnt, level;
  logic q_idle, q_armed, q_select, q_issue;
  logic [15:0] m_lfsr = 16'hACE1, m_prev = 16'hACE1;
  logic [3:0] exp_q[$];
  logic [3:0] last_combo_exp = 0;
  int vectors = 0, errors = 0, n_seen = 0, exp_seen = 0, exp_level = 0, exp_cnt = 0;

  nexys_starship_break_sched dut (
    .Clk(clk), .Reset(reset), .timer_tick(timer_tick), .play_flag(play_flag),
    .gameover_ctrl(gameover_ctrl), .broken(broken), .shield(shield),
    .break_pulse(break_pulse), .break_combo(break_combo), .broken_cnt(broken_cnt),
    .level(level), .q_BS_Idle(q_idle), .q_BS_Armed(q_armed), .q_BS_Select(q_select),
    .q_BS_Issue(q_issue)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int exp_cool(input int lvl);
    return (8 - lvl < 2) ? 2 : 8 - lvl;
  endfunction

  always @(posedge clk) begin
    m_prev <= reset ? 16'hACE1 : m_lfsr;
    m_lfsr <= reset ? 16'hACE1 : step(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every pulse must match a queued expectation
  always @(negedge clk) begin
    logic [3:0] m, c;
    if (!reset && break_pulse != 4'b0) begin
      n_seen++;
      c = m_prev[7:4] == 4'h0 ? 4'h1 : m_prev[7:4];
      last_combo_exp = c;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_pulse: got %b expected no pulse", break_pulse);
      end else begin
        m = exp_q.pop_front();
        check("pulse_onehot", int'($onehot(break_pulse)), 1);
        check("pulse_target", int'(break_pulse & ~m), 0);
        check("break_combo", int'(break_combo), int'(c));
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      timer_tick = 1;
      @(negedge clk);
      timer_tick = 0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic count_issue();
    exp_seen++;
    exp_cnt++;
    if (exp_cnt == 16) begin
      exp_cnt = 0;
      if (exp_level < 7) exp_level++;
    end
  endtask

  task automatic run_break(input int n, input logic [3:0] mask);
    ticks(n - 1);
    exp_q.push_back(mask);
    ticks(1);
    count_issue();
    check("pulse_seen", n_seen, exp_seen);
  endtask

  initial begin
    logic [15:0] nxt;
    bit found;
    repeat (3) @(negedge clk);
    check("rst_pulse", int'(break_pulse), 0);
    check("rst_combo", int'(break_combo), 0);
    check("rst_level", int'(level), 0);
    check("rst_state", int'({q_issue, q_select, q_armed, q_idle}), 1);
    // first break: 8 ticks, pulse on the 2nd edge after the 8th
    reset = 0;
    play_flag = 1;
    @(negedge clk);
    check("armed_after_play", int'(q_armed), 1);
    ticks(7);
    exp_q.push_back(4'b1111);
    timer_tick = 1;
    @(negedge clk);
    timer_tick = 0;
    check("lat0_no_pulse", int'(break_pulse), 0);
    @(negedge clk);
    check("lat1_select", int'(q_select), 1);
    check("lat1_no_pulse", int'(break_pulse), 0);
    @(negedge clk);
    check("lat2_issue", int'(q_issue), 1);
    check("lat2_pulse", int'(break_pulse != 0), 1);
    @(negedge clk);
    check("pulse_width", int'(break_pulse), 0);
    count_issue();
    check("first_seen", n_seen, exp_seen);
    // all shielded: retries each tick, then only station U eligible
    shield = 4'b1111;
    ticks(8 + 3);
    check("shield_armed", int'(q_armed), 1);
    check("shield_no_pulse", n_seen, exp_seen);
    check("combo_held", int'(break_combo), int'(last_combo_exp));
    shield = ~(4'b1 << ST_U);
    exp_q.push_back(4'b1 << ST_U);
    ticks(1);
    count_issue();
    check("shield_release_seen", n_seen, exp_seen);
    shield = 0;
    // two broken: capped in ARMED until one is repaired
    broken = (4'b1 << ST_L) | (4'b1 << ST_R);
    ticks(8 + 2);
    check("cap_broken_cnt", int'(broken_cnt), 2);
    check("cap_armed", int'(q_armed), 1);
    check("cap_no_pulse", n_seen, exp_seen);
    broken = 4'b1 << ST_R;
    exp_q.push_back((4'b1 << ST_L) | (4'b1 << ST_U) | (4'b1 << ST_D));
    repeat (4) @(negedge clk);
    count_issue();
    check("cap_release_seen", n_seen, exp_seen);
    check("cap_release_cnt", int'(broken_cnt), 1);
    broken = 0;
    // time the last tick so the SELECT-cycle lfsr[7:4] is zero
    ticks(7);
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      nxt = step(step(m_lfsr));
      if (nxt[7:4] == 4'h0) found = 1;
      else @(negedge clk);
    end
    check("combo0_found", int'(found), 1);
    exp_q.push_back(4'b1111);
    timer_tick = 1;
    @(negedge clk);
    timer_tick = 0;
    repeat (4) @(negedge clk);
    count_issue();
    check("combo0_seen", n_seen, exp_seen);
    check("combo0_is_1", int'(break_combo), 1);
    // difficulty ramp
    while (exp_seen < 16) run_break(exp_cool(exp_level), 4'b1111);
    check("level1", int'(level), 1);
    while (exp_seen < 112) run_break(exp_cool(exp_level), 4'b1111);
    check("level7", int'(level), 7);
    run_break(2, 4'b1111);
    check("level_sat", int'(level), 7);
    // gameover while in SELECT
    ticks(1);
    timer_tick = 1;
    @(negedge clk);
    timer_tick = 0;
    @(negedge clk);
    check("go_in_select", int'(q_select), 1);
    gameover_ctrl = 1;
    @(negedge clk);
    check("go_idle", int'(q_idle), 1);
    check("go_no_pulse", int'(break_pulse), 0);
    check("go_level_kept", int'(level), 7);
    gameover_ctrl = 0;
    @(negedge clk);
    check("go_rearmed", int'(q_armed), 1);
    check("go_level_clr", int'(level), 0);
    exp_level = 0;
    exp_cnt = 0;
    // reset mid-ARMED
    ticks(3);
    reset = 1;
    broken = 4'b1111;
    @(negedge clk);
    check("mid_rst_pulse", int'(break_pulse), 0);
    check("mid_rst_combo", int'(break_combo), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_idle", int'(q_idle), 1);
    check("broken_cnt4", int'(broken_cnt), 4);
    reset = 0;
    broken = 0;
    @(negedge clk);
    run_break(8, 4'b1111);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
